// File: rtl/mem_bus_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// mem_bus_arbiter_pkg
// Shared encodings and constants for the instruction/data SRAM bus arbiter.
//   - arb_state_t : ST_IDLE / ST_ACCESS / ST_RESP (2 bits)
//   - arb_gnt_t   : GNT_NONE / GNT_INST / GNT_DATA
//   - SEL_WORD    : all four byte lanes enabled (instruction fetch)
//   - ZERO_WORD, WRITE_ENABLE/WRITE_DISABLE, CHIP_ENABLE/CHIP_DISABLE
//   - pick_grant(): IDLE-state grant decision
// -----------------------------------------------------------------------------
package mem_bus_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_RESP   = 2'd2
    } arb_state_t;

    typedef enum logic [1:0] {
        GNT_NONE = 2'd0,
        GNT_INST = 2'd1,
        GNT_DATA = 2'd2
    } arb_gnt_t;

    localparam logic [3:0]  SEL_WORD      = 4'b1111;
    localparam logic [3:0]  SEL_NONE      = 4'b0000;
    localparam logic [31:0] ZERO_WORD     = 32'h0000_0000;
    localparam logic        WRITE_ENABLE  = 1'b1;
    localparam logic        WRITE_DISABLE = 1'b0;
    localparam logic        CHIP_ENABLE   = 1'b1;
    localparam logic        CHIP_DISABLE  = 1'b0;

    // Data wins a tie unless prefer_inst is set (round-robin: data went last).
    function automatic arb_gnt_t pick_grant(input logic inst_req,
                                            input logic data_req,
                                            input logic prefer_inst);
        if (data_req && !(inst_req && prefer_inst)) begin
            return GNT_DATA;
        end else if (inst_req) begin
            return GNT_INST;
        end else begin
            return GNT_NONE;
        end
    endfunction

endpackage

// File: rtl/mem_bus_arbiter.sv
// -----------------------------------------------------------------------------
// mem_bus_arbiter
// Shares one single-port, word-addressed SRAM bus between the instruction
// fetch port and the MEM-stage data port. One requester is granted at a time;
// the access lasts WAIT_CYCLES+1 cycles minimum, extended while sram_ready_i
// is low, and completion is signalled by a one-cycle valid pulse.
//
// Optional build macro: MEM_ARB_ROUND_ROBIN_EN
//   defined   : a last-grant register (reset: INST) lets the port not granted
//               last win when both request in IDLE.
//   undefined : fixed data-over-instruction priority.
//
// Ports:
//   clk, rst            clock, asynchronous active-low reset
//   inst_*              fetch request (ce, addr) and response (rdata, valid)
//   data_*              data request (ce, we, sel, addr, wdata), response
//   sram_*              shared SRAM bus (ce, we, sel, addr, wdata, rdata, ready)
//   stall_req_o         combinational stall request to the pipeline
// -----------------------------------------------------------------------------
module mem_bus_arbiter
    import mem_bus_arbiter_pkg::*;
#(
    parameter int WAIT_CYCLES = 1,
    parameter int CNT_W       = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        inst_ce_i,
    input  logic [31:0] inst_addr_i,
    output logic [31:0] inst_rdata_o,
    output logic        inst_valid_o,
    input  logic        data_ce_i,
    input  logic        data_we_i,
    input  logic [3:0]  data_sel_i,
    input  logic [31:0] data_addr_i,
    input  logic [31:0] data_wdata_i,
    output logic [31:0] data_rdata_o,
    output logic        data_valid_o,
    output logic        sram_ce_o,
    output logic        sram_we_o,
    output logic [3:0]  sram_sel_o,
    output logic [31:0] sram_addr_o,
    output logic [31:0] sram_wdata_o,
    input  logic [31:0] sram_rdata_i,
    input  logic        sram_ready_i,
    output logic        stall_req_o
);

    arb_state_t        state_reg;
    arb_gnt_t          gnt_reg;
    arb_gnt_t          gnt_next;
    logic [CNT_W-1:0]  cnt_reg;
    logic              prefer_inst;

    logic              sram_ce_reg;
    logic              sram_we_reg;
    logic [3:0]        sram_sel_reg;
    logic [31:0]       sram_addr_reg;
    logic [31:0]       sram_wdata_reg;
    logic [31:0]       inst_rdata_reg;
    logic [31:0]       data_rdata_reg;
    logic              inst_valid_reg;
    logic              data_valid_reg;

`ifdef MEM_ARB_ROUND_ROBIN_EN
    // 1 = last grant went to DATA, 0 = INST (reset value).
    logic              last_data_reg;
    assign prefer_inst = last_data_reg;
`else
    assign prefer_inst = 1'b0;
`endif

    assign gnt_next = pick_grant(inst_ce_i, data_ce_i, prefer_inst);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg      <= ST_IDLE;
            gnt_reg        <= GNT_NONE;
            cnt_reg        <= '0;
            sram_ce_reg    <= CHIP_DISABLE;
            sram_we_reg    <= WRITE_DISABLE;
            sram_sel_reg   <= SEL_NONE;
            sram_addr_reg  <= ZERO_WORD;
            sram_wdata_reg <= ZERO_WORD;
            inst_rdata_reg <= ZERO_WORD;
            data_rdata_reg <= ZERO_WORD;
            inst_valid_reg <= 1'b0;
            data_valid_reg <= 1'b0;
`ifdef MEM_ARB_ROUND_ROBIN_EN
            last_data_reg  <= 1'b0;
`endif
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (gnt_next != GNT_NONE) begin
                        // Request is latched here; later ce changes are ignored.
                        if (gnt_next == GNT_DATA) begin
                            sram_we_reg    <= data_we_i;
                            sram_sel_reg   <= data_sel_i;
                            sram_addr_reg  <= data_addr_i;
                            sram_wdata_reg <= data_wdata_i;
                        end else begin
                            sram_we_reg    <= WRITE_DISABLE;
                            sram_sel_reg   <= SEL_WORD;
                            sram_addr_reg  <= inst_addr_i;
                            sram_wdata_reg <= ZERO_WORD;
                        end
                        sram_ce_reg <= CHIP_ENABLE;
                        cnt_reg     <= CNT_W'(WAIT_CYCLES);
                        gnt_reg     <= gnt_next;
                        state_reg   <= ST_ACCESS;
`ifdef MEM_ARB_ROUND_ROBIN_EN
                        last_data_reg <= (gnt_next == GNT_DATA);
`endif
                    end
                end

                ST_ACCESS: begin
                    if (cnt_reg != '0) begin
                        cnt_reg <= cnt_reg - CNT_W'(1);
                    end else if (sram_ready_i) begin
                        // Valid is set on the way into RESP so it is high
                        // for exactly the RESP cycle.
                        if (gnt_reg == GNT_INST) begin
                            inst_rdata_reg <= sram_rdata_i;
                            inst_valid_reg <= 1'b1;
                        end else begin
                            if (sram_we_reg == WRITE_DISABLE) begin
                                data_rdata_reg <= sram_rdata_i;
                            end
                            data_valid_reg <= 1'b1;
                        end
                        sram_ce_reg  <= CHIP_DISABLE;
                        sram_we_reg  <= WRITE_DISABLE;
                        sram_sel_reg <= SEL_NONE;
                        state_reg    <= ST_RESP;
                    end
                end

                ST_RESP: begin
                    inst_valid_reg <= 1'b0;
                    data_valid_reg <= 1'b0;
                    gnt_reg        <= GNT_NONE;
                    state_reg      <= ST_IDLE;
                end

                default: begin
                    state_reg <= ST_IDLE;
                end
            endcase
        end
    end

    assign sram_ce_o    = sram_ce_reg;
    assign sram_we_o    = sram_we_reg;
    assign sram_sel_o   = sram_sel_reg;
    assign sram_addr_o  = sram_addr_reg;
    assign sram_wdata_o = sram_wdata_reg;
    assign inst_rdata_o = inst_rdata_reg;
    assign data_rdata_o = data_rdata_reg;
    assign inst_valid_o = inst_valid_reg;
    assign data_valid_o = data_valid_reg;

    // Combinational so the pipeline is released in the valid cycle itself.
    assign stall_req_o = (inst_ce_i & ~inst_valid_reg) | (data_ce_i & ~data_valid_reg);

endmodule

// File: doc/mem_bus_arbiter.md
Name: mem_bus_arbiter

Overview:
- Shares one single-port, word-addressed SRAM bus between the instruction-fetch port and the MEM-stage data port.
- The MEM-stage data port carries ce, we, sel, addr and wdata.
- Grants one requester at a time, sequences a fixed-wait-state access extended by `sram_ready`, and returns read data with a one-cycle valid pulse.
- Raises `stall_req` to the pipeline controller while any accepted request is outstanding.

Parameters:
- WAIT_CYCLES, 1, minimum ACCESS-state cycles minus one; legal range 0..15.
- CNT_W, 4, width of the wait counter; must hold WAIT_CYCLES.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-low reset (rst==0 resets)
- inst_ce_i  in  1  fetch request, held until inst_valid_o
- inst_addr_i  in  32  fetch address
- inst_rdata_o  out  32  fetched word
- inst_valid_o  out  1  one-cycle completion pulse for fetch
- data_ce_i  in  1  data request (MEM-stage ce), held until data_valid_o
- data_we_i  in  1  1 = write
- data_sel_i  in  4  byte lanes, bit3 = bits[31:24]
- data_addr_i  in  32  data address
- data_wdata_i  in  32  store data
- data_rdata_o  out  32  loaded word (raw; lane extraction stays in MEM stage)
- data_valid_o  out  1  one-cycle completion pulse for data
- sram_ce_o  out  1  bus chip enable
- sram_we_o  out  1  bus write enable
- sram_sel_o  out  4  bus byte enables
- sram_addr_o  out  32  bus address
- sram_wdata_o  out  32  bus write data
- sram_rdata_i  in  32  bus read data
- sram_ready_i  in  1  bus ready; sampled only when the wait counter is 0
- stall_req_o  out  1  stall request to the pipeline controller

Behaviour:
- Reset values: all outputs 0; FSM=IDLE; counter=0; grant=NONE.
- FSM states: IDLE, ACCESS, RESP.
- IDLE:
  - If data_ce_i, grant DATA; else if inst_ce_i, grant INST.
  - On a grant: register addr/sel/we/wdata onto the sram_* outputs, load counter=WAIT_CYCLES, go to ACCESS.
  - INST grant drives sram_sel=4'b1111, sram_we=0, sram_wdata=0.
- ACCESS:
  - sram_ce=1 and all sram_* outputs stay stable.
  - Counter decrements each cycle while nonzero.
  - When counter==0 and sram_ready_i==1: capture sram_rdata_i (reads only), drop sram_ce/we/sel to 0, go to RESP.
  - If sram_ready_i==0 at counter==0, hold indefinitely.
- RESP:
  - Pulse the granted requester's valid for exactly one cycle, then go to IDLE.
  - No grant is made in RESP.
- Read data and writes:
  - The rdata registers hold their value until the next read completion of that port.
  - Writes also pulse data_valid_o; data_rdata_o is unchanged on a write.
- Latency: request seen in IDLE at cycle 0 → valid in cycle WAIT_CYCLES+2, with ready held high.
- Throughput: one access per WAIT_CYCLES+3 cycles.
- Request latching: requests are latched at grant. A requester dropping ce mid-access does not abort; the access completes and valid still pulses.
- data_sel_i==4'b0000 with ce=1: the access is performed with sel 0000, so no bytes are written.
- stall_req_o = (inst_ce_i & ~inst_valid_o) | (data_ce_i & ~data_valid_o). This is combinational and deasserts in the valid cycle.
- Simultaneous inst and data requests in IDLE: data wins (older instruction); inst stays pending and stall stays high.
- Reset asserted mid-access: immediate return to IDLE, all outputs 0, no valid pulse.

Optional Feature:
- Macro: MEM_ARB_ROUND_ROBIN_EN.
- Defined: a 1-bit last-grant register (reset: INST). When both ports request in IDLE, the port not granted last wins.
- Undefined: fixed data-over-instruction priority; no last-grant register.

Decomposition:
- Shared package (the macro include file):
  - state encodings ST_IDLE/ST_ACCESS/ST_RESP (2 bits)
  - grant encodings GNT_NONE/GNT_INST/GNT_DATA
  - SEL_WORD=4'b1111
  - reuse of the existing ZEROWORD, WRITEENABLE/WRITEDISABLE and CHIPENABLE/CHIPDISABLE macros
- No sub-module: the counter and FSM are small and tightly coupled, so the block stays single-module.

Test Plan:
- WAIT_CYCLES=1, ready=1, inst_ce=1, addr=0x0000_0100, rdata=0x2402_0005 → sram_ce high in cycles 1–2 with sel=1111; inst_valid pulses in cycle 3 with inst_rdata=0x2402_0005; stall high in cycles 0–2.
- Data store: we=1, sel=4'b0100, addr=0x0000_0201, wdata=0x5A5A_5A5A → bus carries exactly these values for 2 cycles; data_valid pulses in cycle 3; data_rdata unchanged.
- inst and data requests both raised in cycle 0 → data granted first, data_valid in cycle 3; inst granted in cycle 4, inst_valid in cycle 7. With MEM_ARB_ROUND_ROBIN_EN and last grant=DATA, inst wins instead.
- ready held 0 for 5 cycles at counter 0 → FSM stays in ACCESS, bus stable, no valid pulse; valid follows 1 cycle after ready rises.
- Reset pulled low in the 2nd ACCESS cycle of a read → all outputs 0 asynchronously; after release, no stray valid pulse; a re-request completes normally.
- WAIT_CYCLES=0, back-to-back inst fetches of 0x0, 0x4 → valids in cycles 2 and 5.
